thermostat_ctrl: RTL and testbench

- Heating/cooling thermostat controller.
- Decodes mode and temperature-sensor flags into heater, air-conditioner and fan drive signals.
- Drive outputs are purely combinational.
- A clocked side block tracks run-time statistics and flags sensor faults. It sits between the sensor-interface logic and the HVAC actuator drivers.

---
 rtl/thermostat_pkg.sv | 9 +
 rtl/thermostat_sat_counter.sv | 39 +++
 rtl/thermostat_ctrl.sv | 96 +++++++++
 tb/tb_thermostat_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/thermostat_pkg.sv
// Shared constants for the thermostat controller: mode encoding and default counter width.
package thermostat_pkg;

    localparam logic MODE_COOL = 1'b0;
    localparam logic MODE_HEAT = 1'b1;

    localparam int CNT_W_DEFAULT = 16;

endpackage : thermostat_pkg

// File: rtl/thermostat_sat_counter.sv
// Up-counter with enable and synchronous reset that sticks at all-ones instead of wrapping.
module thermostat_sat_counter
    import thermostat_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;
    logic         at_max_s;

    // Next value: advance only when enabled and not already saturated.
    always_comb begin
        count_nxt_s = count_r;
        at_max_s    = (count_r == {W{1'b1}});
        if (en && !at_max_s) begin
            count_nxt_s = count_r + W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule : thermostat_sat_counter

// File: rtl/thermostat_ctrl.sv
// Thermostat controller: decodes mode/sensor flags into heater, aircon and fan drives, plus run-time stats.
// Define THERMOSTAT_OUTREG_EN to register the drive outputs (1-cycle latency, cleared by reset).
module thermostat_ctrl
    import thermostat_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             too_cold,
    input  logic             too_hot,
    input  logic             fan_on,
    output logic             heater,
    output logic             aircon,
    output logic             fan,
    output logic [CNT_W-1:0] heat_cycles,
    output logic [CNT_W-1:0] cool_cycles,
    output logic             sensor_fault
);

    logic heater_s;
    logic aircon_s;
    logic fan_s;
    logic sensor_fault_r;

    // Only the active mode's flag can call for conditioning, so heater and aircon are exclusive.
    always_comb begin
        heater_s = 1'b0;
        aircon_s = 1'b0;
        if (mode == MODE_HEAT) begin
            heater_s = too_cold;
            aircon_s = 1'b0;
        end else begin
            heater_s = 1'b0;
            aircon_s = too_hot;
        end
        fan_s = heater_s | aircon_s | fan_on;
    end

`ifdef THERMOSTAT_OUTREG_EN
    logic heater_r;
    logic aircon_r;
    logic fan_r;

    // Registered drive stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            heater_r <= 1'b0;
            aircon_r <= 1'b0;
            fan_r    <= 1'b0;
        end else begin
            heater_r <= heater_s;
            aircon_r <= aircon_s;
            fan_r    <= fan_s;
        end
    end

    assign heater = heater_r;
    assign aircon = aircon_r;
    assign fan    = fan_r;
`else
    assign heater = heater_s;
    assign aircon = aircon_s;
    assign fan    = fan_s;
`endif

    // Statistics count whatever is actually presented to the actuators.
    thermostat_sat_counter #(.W(CNT_W)) u_heat_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (heater),
        .count (heat_cycles)
    );

    thermostat_sat_counter #(.W(CNT_W)) u_cool_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (aircon),
        .count (cool_cycles)
    );

    // Sticky fault on contradictory sensor flags; reset takes priority over a same-edge set.
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_fault_r <= 1'b0;
        end else if (too_cold && too_hot) begin
            sensor_fault_r <= 1'b1;
        end else begin
            sensor_fault_r <= sensor_fault_r;
        end
    end

    assign sensor_fault = sensor_fault_r;

endmodule : thermostat_ctrl

// File: tb/tb_thermostat_ctrl.sv
// Directed and random bench for thermostat_ctrl (default build, combinational drives).
module tb_thermostat_ctrl;

    logic        clk_s = 1'b0;
    logic        reset_s;
    logic        mode_s, too_cold_s, too_hot_s, fan_on_s;
    logic        heater_s, aircon_s, fan_s, fault_s;
    logic [15:0] heat_s, cool_s;
    logic        heater3_s, aircon3_s, fan3_s, fault3_s;
    logic [2:0]  heat3_s, cool3_s;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk_s = ~clk_s;

    thermostat_ctrl #(.CNT_W(16)) dut (
        .clk(clk_s), .reset(reset_s), .mode(mode_s), .too_cold(too_cold_s),
        .too_hot(too_hot_s), .fan_on(fan_on_s), .heater(heater_s), .aircon(aircon_s),
        .fan(fan_s), .heat_cycles(heat_s), .cool_cycles(cool_s), .sensor_fault(fault_s)
    );

    thermostat_ctrl #(.CNT_W(3)) dut3 (
        .clk(clk_s), .reset(reset_s), .mode(mode_s), .too_cold(too_cold_s),
        .too_hot(too_hot_s), .fan_on(fan_on_s), .heater(heater3_s), .aircon(aircon3_s),
        .fan(fan3_s), .heat_cycles(heat3_s), .cool_cycles(cool3_s), .sensor_fault(fault3_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic m, input logic c, input logic h, input logic f);
        mode_s     = m;
        too_cold_s = c;
        too_hot_s  = h;
        fan_on_s   = f;
    endtask

    // {mode, too_cold, too_hot, fan_on, heater, aircon, fan}, hand-derived
    logic [6:0] vec_tbl [0:8];
    initial begin
        vec_tbl[0] = 7'b1000_000; // winter idle
        vec_tbl[1] = 7'b1100_101; // winter cold
        vec_tbl[2] = 7'b1010_000; // winter hot ignored
        vec_tbl[3] = 7'b0010_011; // summer hot
        vec_tbl[4] = 7'b0100_000; // summer cold ignored
        vec_tbl[5] = 7'b1001_001; // fan only, heat mode
        vec_tbl[6] = 7'b0001_001; // fan only, cool mode
        vec_tbl[7] = 7'b1110_101; // both flags, heat wins
        vec_tbl[8] = 7'b0110_011; // both flags, cool wins
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] v;
        logic       eh, ea;
        reset_s = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_s);
        @(negedge clk_s);
        check("rst_heat", 32'(heat_s), 32'd0);
        check("rst_cool", 32'(cool_s), 32'd0);
        check("rst_fault", 32'(fault_s), 32'd0);
        check("rst_heat3", 32'(heat3_s), 32'd0);

        // Drive decode while reset is held: reset must not gate the drives.
        for (int i = 0; i < 9; i++) begin
            v = vec_tbl[i];
            drive(v[6], v[5], v[4], v[3]);
            #1;
            check($sformatf("vec%0d_heater", i), 32'(heater_s), 32'(v[2]));
            check($sformatf("vec%0d_aircon", i), 32'(aircon_s), 32'(v[1]));
            check($sformatf("vec%0d_fan", i), 32'(fan_s), 32'(v[0]));
        end
        @(posedge clk_s);
        @(negedge clk_s);
        check("rst_hold_heat", 32'(heat_s), 32'd0);
        check("rst_hold_fault", 32'(fault_s), 32'd0);

        // Heat run: 5 cycles, then 5 more to saturate the 3-bit instance.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        reset_s = 1'b0;
        repeat (5) @(posedge clk_s);
        @(negedge clk_s);
        check("heat5", 32'(heat_s), 32'd5);
        check("cool5", 32'(cool_s), 32'd0);
        check("heat5_w3", 32'(heat3_s), 32'd5);
        check("fault_clear", 32'(fault_s), 32'd0);
        repeat (5) @(posedge clk_s);
        @(negedge clk_s);
        check("heat10", 32'(heat_s), 32'd10);
        check("heat_sat_w3", 32'(heat3_s), 32'd7);

        // Cool run: 3 cycles.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk_s);
        @(negedge clk_s);
        check("cool3", 32'(cool_s), 32'd3);
        check("heat_hold", 32'(heat_s), 32'd10);
        check("heat_hold_w3", 32'(heat3_s), 32'd7);

        // Contradictory flags: fault is registered, drives follow active mode.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("fault_pre_edge", 32'(fault_s), 32'd0);
        check("both_heat_heater", 32'(heater_s), 32'd1);
        mode_s = 1'b0;
        #1;
        check("both_cool_aircon", 32'(aircon_s), 32'd1);
        check("both_cool_heater", 32'(heater_s), 32'd0);
        @(posedge clk_s);
        @(negedge clk_s);
        check("fault_set", 32'(fault_s), 32'd1);
        check("cool4", 32'(cool_s), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_s);
        @(negedge clk_s);
        check("fault_sticky", 32'(fault_s), 32'd1);
        check("cool4_idle", 32'(cool_s), 32'd4);

        // Reset beats a simultaneous fault set.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        reset_s = 1'b1;
        @(posedge clk_s);
        @(negedge clk_s);
        check("fault_rst_wins", 32'(fault_s), 32'd0);
        check("heat_rst", 32'(heat_s), 32'd0);
        check("cool_rst", 32'(cool_s), 32'd0);
        reset_s = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Random vectors changed on both edges; drives compared against the equations.
        for (int n = 0; n < 200; n++) begin
            if (n % 2 == 0) @(posedge clk_s);
            else            @(negedge clk_s);
            #1;
            drive(1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            #1;
            eh = mode_s & too_cold_s;
            ea = ~mode_s & too_hot_s;
            check("rnd_heater", 32'(heater_s), 32'(eh));
            check("rnd_aircon", 32'(aircon_s), 32'(ea));
            check("rnd_fan", 32'(fan_s), 32'(eh | ea | fan_on_s));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_thermostat_ctrl
